// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: op codes, FSM states, default widths.
// Pure declarations; no latency or flow control of its own.
// Imported by the controller top and its round-robin arbiter.
package alu_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OP_W  = 3;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: prio decides only when both requesters are valid.
// Zero latency (combinational).
// No flow control; the caller qualifies the grant with its own ready logic.
module alu_rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters, holding operands EXEC_CYCLES cycles.
// Latency: accept at edge k -> response valid after edge k+EXEC_CYCLES.
// Backpressure: a stalled response holds the FSM in RESP; no new request is accepted meanwhile.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int              WIDTH       = DEF_WIDTH,
    parameter int              OP_W        = DEF_OP_W,
    parameter int              EXEC_CYCLES = 1,
    parameter logic [OP_W-1:0] OP_DIV      = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [1:0]       grant;

    alu_rr_arb2 u_arb (
        .valid (({req1_valid, req0_valid})),
        .prio  (prio_q),
        .grant (grant)
    );

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = '0;

        case (state_q)
            IDLE: begin
                // Ready is masked during reset so a reset edge never doubles as an accept.
                req0_ready = grant[0] & ~rst;
                req1_ready = grant[1] & ~rst;
                if (grant != 2'b00) begin
                    owner_d = grant[1];
                    a_d     = grant[1] ? req1_a  : req0_a;
                    b_d     = grant[1] ? req1_b  : req0_b;
                    op_d    = grant[1] ? req1_op : req0_op;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_sel = op_q;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (op_q == OP_DIV && b_q == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        result_d = alu_result;
                        err_d    = 1'b0;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if ((owner_q ? rsp1_ready : rsp0_ready)) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU beside the DUT, scoreboard of expected responses.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic        owner;
        logic [31:0] result;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        busy;

    // second instance with a 4-cycle hold, requester 1 unused
    logic        q4_valid = 1'b0, q4_ready, r4_valid, r4_ready = 1'b0, r4_err, busy4;
    logic [31:0] q4_a = '0, q4_b = '0, r4_result, a4_a, a4_b, a4_result;
    logic [2:0]  q4_op = '0, a4_sel;
    logic        d4_req1_ready, d4_rsp1_valid, d4_rsp1_err;
    logic [31:0] d4_rsp1_result;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_NOT: return ~a;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_NEG: return -a;
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            default: return (b == 0) ? 32'hDEAD_BEEF : a / b;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic owner, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.owner  = owner;
        e.err    = (op == OP_DIV && b == 0);
        e.result = e.err ? 32'd0 : alu_model(op, a, b);
        return e;
    endfunction

    always_comb alu_result = alu_model(alu_sel, alu_a, alu_b);
    always_comb a4_result  = alu_model(a4_sel, a4_a, a4_b);

    alu_share_ctrl #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .busy(busy)
    );

    alu_share_ctrl #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(q4_valid), .req0_ready(q4_ready), .req0_a(q4_a), .req0_b(q4_b), .req0_op(q4_op),
        .req1_valid(1'b0), .req1_ready(d4_req1_ready), .req1_a(32'd0), .req1_b(32'd0), .req1_op(3'd0),
        .rsp0_valid(r4_valid), .rsp0_ready(r4_ready), .rsp0_result(r4_result), .rsp0_err(r4_err),
        .rsp1_valid(d4_rsp1_valid), .rsp1_ready(1'b0), .rsp1_result(d4_rsp1_result), .rsp1_err(d4_rsp1_err),
        .alu_a(a4_a), .alu_b(a4_b), .alu_sel(a4_sel), .alu_result(a4_result), .busy(busy4)
    );

    // Scoreboard producer: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (req0_valid && req0_ready) exp_q.push_back(make_exp(1'b0, req0_op, req0_a, req0_b));
            if (req1_valid && req1_ready) exp_q.push_back(make_exp(1'b1, req1_op, req1_a, req1_b));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        n_checks++; if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy}); end
        n_checks++; if ({alu_a, alu_b, alu_sel, rsp0_result} !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", alu_a, alu_b, alu_sel, rsp0_result); end
        tick; rst = 1'b0; req0_valid = 1'b0;
    endtask

    task automatic test_single;
        exp_t e;
        tick; req0_a = 5; req0_b = 3; req0_op = OP_ADD; req0_valid = 1'b1; rsp0_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", req0_ready); end
        tick; req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, req0_ready, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 32'd5, 32'd3, OP_ADD}) begin
            n_fail++; $display("FAIL single_exec: got busy=%b rdy=%b a=%0h b=%0h sel=%0h expected 1 0 5 3 4", busy, req0_ready, alu_a, alu_b, alu_sel); end
        n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL single_early: got %b expected 00", {rsp0_valid, rsp1_valid}); end
        @(negedge clk);
        n_checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_fail++; $display("FAIL single_latency: got %b expected 10", {rsp0_valid, rsp1_valid}); end
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL single_sb: got empty queue expected 1 entry"); end
        else begin
            e = exp_q.pop_front();
            n_checks++; if ({rsp0_result, rsp0_err} !== {e.result, e.err}) begin n_fail++; $display("FAIL single_sb: got %0h/%b expected %0h/%b", rsp0_result, rsp0_err, e.result, e.err); end
        end
        n_checks++; if ({rsp0_result, rsp0_err} !== {32'd8, 1'b0}) begin n_fail++; $display("FAIL single_result: got %0d/%b expected 8/0", rsp0_result, rsp0_err); end
        tick;
        @(negedge clk);
        n_checks++; if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL single_done: got %b expected 000", {rsp0_valid, rsp1_valid, busy}); end
    endtask

    task automatic test_both;
        exp_t e;
        int served;
        logic who;
        logic [31:0] res;
        rst = 1'b1;
        req0_a = 10;    req0_b = 4;    req0_op = OP_SUB; req0_valid = 1'b1;
        req1_a = 'hF0;  req1_b = 'h3C; req1_op = OP_AND; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick; rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL both_first_grant: got %b expected 01", {req1_ready, req0_ready}); end
        served = 0;
        for (int cyc = 0; cyc < 40 && served < 4; cyc++) begin
            @(negedge clk);
            n_checks++; if (busy && (req0_ready || req1_ready)) begin n_fail++; $display("FAIL both_ready_busy: got %b expected 00", {req1_ready, req0_ready}); end
            if (rsp0_valid || rsp1_valid) begin
                who = rsp1_valid;
                res = who ? rsp1_result : rsp0_result;
                n_checks++; if (rsp0_valid && rsp1_valid) begin n_fail++; $display("FAIL both_dual_rsp: got 11 expected one-hot"); end
                n_checks++; if (who !== 1'(served % 2)) begin n_fail++; $display("FAIL both_order: got owner %b expected %b", who, 1'(served % 2)); end
                if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL both_sb: got empty queue expected entry"); end
                else begin
                    e = exp_q.pop_front();
                    n_checks++; if ({who, res} !== {e.owner, e.result}) begin n_fail++; $display("FAIL both_sb: got %b/%0h expected %b/%0h", who, res, e.owner, e.result); end
                end
                if (served < 2) begin
                    n_checks++; if (res !== (who ? 32'h30 : 32'd6)) begin n_fail++; $display("FAIL both_value: got %0h expected %0h", res, who ? 32'h30 : 32'd6); end
                end
                served++;
                if (served == 4) begin tick; req0_valid = 1'b0; req1_valid = 1'b0; end
            end
        end
        n_checks++; if (served != 4) begin n_fail++; $display("FAIL both_timeout: got %0d responses expected 4", served); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL both_leftover: got %0d entries expected 0", exp_q.size()); end
    endtask

    task automatic test_div;
        exp_t e;
        logic found;
        for (int k = 0; k < 2; k++) begin
            tick; req1_a = 100; req1_b = (k == 0) ? 32'd0 : 32'd7; req1_op = OP_DIV; req1_valid = 1'b1; rsp1_ready = 1'b1;
            tick; req1_valid = 1'b0;
            found = 1'b0;
            for (int cyc = 0; cyc < 10 && !found; cyc++) begin
                @(negedge clk);
                found = rsp1_valid;
            end
            n_checks++; if (!found) begin n_fail++; $display("FAIL div_timeout: got no rsp1_valid expected response"); end
            else begin
                if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL div_sb: got empty queue expected entry"); end
                else begin
                    e = exp_q.pop_front();
                    n_checks++; if ({rsp1_result, rsp1_err} !== {e.result, e.err}) begin n_fail++; $display("FAIL div_sb: got %0d/%b expected %0d/%b", rsp1_result, rsp1_err, e.result, e.err); end
                end
                n_checks++; if ({rsp1_result, rsp1_err} !== ((k == 0) ? {32'd0, 1'b1} : {32'd14, 1'b0})) begin
                    n_fail++; $display("FAIL div_value%0d: got %0d/%b expected %0d/%b", k, rsp1_result, rsp1_err, (k == 0) ? 0 : 14, (k == 0) ? 1 : 0); end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        logic found;
        tick; req0_a = 1; req0_b = 2; req0_op = OP_ADD; req0_valid = 1'b1; rsp0_ready = 1'b0;
        req1_a = 7; req1_b = 7; req1_op = OP_ADD; req1_valid = 1'b1;
        tick; req0_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            found = rsp0_valid;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL bp_timeout: got no rsp0_valid expected response"); end
        if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_sb: got empty queue expected entry"); end
        else begin
            e = exp_q.pop_front();
            n_checks++; if ({e.owner, rsp0_result} !== {1'b0, 32'd3}) begin n_fail++; $display("FAIL bp_sb: got %b/%0d expected 0/3", e.owner, rsp0_result); end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++; if ({rsp0_valid, rsp0_result, req0_ready, req1_ready, busy} !== {1'b1, 32'd3, 1'b0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b r=%0d rdy=%b%b busy=%b expected 1 3 00 1", i, rsp0_valid, rsp0_result, req0_ready, req1_ready, busy); end
        end
        tick; rsp0_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", rsp0_valid); end
        tick; req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({rsp0_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_idle: got %b expected 00", {rsp0_valid, busy}); end
    endtask

    task automatic test_exec4;
        tick; q4_a = 'h10000; q4_b = 'h10000; q4_op = OP_MUL; q4_valid = 1'b1; r4_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (q4_ready !== 1'b1) begin n_fail++; $display("FAIL e4_ready: got %b expected 1", q4_ready); end
        tick; q4_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if ({a4_a, a4_b, a4_sel, r4_valid, busy4, q4_ready} !== {32'h10000, 32'h10000, OP_MUL, 1'b0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL e4_hold%0d: got a=%0h b=%0h sel=%0h v=%b busy=%b expected 10000 10000 6 0 1", i, a4_a, a4_b, a4_sel, r4_valid, busy4); end
        end
        @(negedge clk);
        n_checks++; if ({r4_valid, r4_result, r4_err} !== {1'b1, 32'd0, 1'b0}) begin n_fail++; $display("FAIL e4_result: got %b/%0h/%b expected 1/0/0", r4_valid, r4_result, r4_err); end
        tick;
        @(negedge clk);
        n_checks++; if ({r4_valid, busy4} !== 2'b00) begin n_fail++; $display("FAIL e4_idle: got %b expected 00", {r4_valid, busy4}); end
    endtask

    task automatic test_reset_exec;
        exp_t e;
        logic found;
        tick; req0_a = 9; req0_b = 9; req0_op = OP_ADD; req0_valid = 1'b1; rsp0_ready = 1'b1;
        tick; req0_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rx_in_exec: got busy %b expected 1", busy); end
        tick; rst = 1'b0;
        req0_a = 2; req0_b = 3; req0_op = OP_ADD; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        n_checks++; if ({rsp0_valid, rsp1_valid, busy, rsp0_err, alu_a, alu_b, alu_sel, rsp0_result} !== '0) begin
            n_fail++; $display("FAIL rx_outputs: got v=%b%b busy=%b err=%b alu=%0h/%0h/%0h res=%0h expected zeros", rsp0_valid, rsp1_valid, busy, rsp0_err, alu_a, alu_b, alu_sel, rsp0_result); end
        n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rx_prio: got %b expected 01", {req1_ready, req0_ready}); end
        tick; req0_valid = 1'b0; req1_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            found = rsp0_valid;
            n_checks++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rx_rsp1: got %b expected 0", rsp1_valid); end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rx_timeout: got no rsp0_valid expected response"); end
        else if (exp_q.size() != 1) begin n_checks++; n_fail++; $display("FAIL rx_sb: got %0d entries expected 1", exp_q.size()); end
        else begin
            e = exp_q.pop_front();
            n_checks++; if ({rsp0_result, rsp0_err} !== {e.result, e.err}) begin n_fail++; $display("FAIL rx_sb: got %0d/%b expected %0d/%b", rsp0_result, rsp0_err, e.result, e.err); end
            n_checks++; if (rsp0_result !== 32'd5) begin n_fail++; $display("FAIL rx_value: got %0d expected 5", rsp0_result); end
        end
        tick;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_div();
        test_backpressure();
        test_exec4();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
